// File: rtl/fir_line_ctrl.sv
// Line/window sequencer for the 2D FIR: pixel position, line-buffer bank rotation, window valid, sync delay.
// Optional coefficient-load sequencer is built only when FIR_COEF_LOAD_EN is defined.
module fir_line_ctrl #(
    parameter int unsigned MAX_COLS = 1600,
    parameter int unsigned MAX_ROWS = 900,
    parameter int unsigned KSIZE    = 5,
    parameter int unsigned COL_W    = 11,
    parameter int unsigned ROW_W    = 10,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dv_i,
    input  logic             hs_i,
    input  logic             vs_i,
    output logic             wr_en_o,
    output logic [1:0]       wr_bank_o,
    output logic [COL_W-1:0] wr_addr_o,
    output logic [1:0]       old_bank_o,
    output logic             win_valid_o,
    output logic [ROW_W-1:0] row_o,
    output logic             ovf_o,
    output logic [4:0]       coef_addr_o,
    output logic             coef_we_o,
    output logic             coef_busy_o,
    output logic             dv_o,
    output logic             hs_o,
    output logic             vs_o
);
    localparam int unsigned NUM_LINES = KSIZE - 1;
    localparam int unsigned SYNC_W    = 3 * PIPE_LAT;

    typedef enum logic [1:0] {WAIT_VS, FILL, RUN} state_e;

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             line_full_q, line_full_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       bank_q, bank_d;
    logic [1:0]       old_bank_q, old_bank_d;
    logic             ovf_q, ovf_d;
    logic             wr_en_q, wr_en_d;
    logic [COL_W-1:0] wr_addr_q, wr_addr_d;
    logic             win_valid_q, win_valid_d;
    logic             hs_prev_q, vs_prev_q;
    logic [SYNC_W-1:0] sync_q;

    logic vs_rise, vs_fall, hs_rise, accept;

    assign vs_rise = vs_i & ~vs_prev_q;
    assign vs_fall = ~vs_i & vs_prev_q;
    assign hs_rise = hs_i & ~hs_prev_q;
    assign accept  = dv_i & ~hs_i & ~vs_i & (state_q != WAIT_VS);

    // Next-state: frame sync dominates; otherwise pixel write and line-end rotation.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_full_d = line_full_q;
        row_d       = row_q;
        bank_d      = bank_q;
        ovf_d       = ovf_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        win_valid_d = 1'b0;

        if (vs_i) begin
            col_d       = '0;
            line_full_d = 1'b0;
            row_d       = '0;
            bank_d      = 2'd0;
            if (state_q != WAIT_VS) state_d = FILL;
            if (vs_rise)            ovf_d   = 1'b0;
        end else begin
            if (vs_fall) state_d = FILL;
            if (accept) begin
                if (line_full_q) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_d     = 1'b1;
                    wr_addr_d   = col_q;
                    win_valid_d = (state_q == RUN) && (col_q >= COL_W'(KSIZE - 1));
                    if (col_q == COL_W'(MAX_COLS - 1)) line_full_d = 1'b1;
                    else                               col_d       = col_q + COL_W'(1);
                end
            end
            // An hs edge on an empty line is a no-op.
            if (hs_rise && ((col_q != '0) || line_full_q)) begin
                col_d       = '0;
                line_full_d = 1'b0;
                bank_d      = bank_q + 2'd1;
                if (row_q == ROW_W'(MAX_ROWS - 1)) ovf_d = 1'b1;
                else                               row_d = row_q + ROW_W'(1);
                if ((state_q == FILL) && (row_d >= ROW_W'(KSIZE - 1))) state_d = RUN;
            end
        end

        old_bank_d = (row_d >= ROW_W'(NUM_LINES)) ? bank_d + 2'd1 : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_VS;
            col_q       <= '0;
            line_full_q <= 1'b0;
            row_q       <= '0;
            bank_q      <= 2'd0;
            old_bank_q  <= 2'd0;
            ovf_q       <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            win_valid_q <= 1'b0;
            hs_prev_q   <= 1'b0;
            vs_prev_q   <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_full_q <= line_full_d;
            row_q       <= row_d;
            bank_q      <= bank_d;
            old_bank_q  <= old_bank_d;
            ovf_q       <= ovf_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            win_valid_q <= win_valid_d;
            hs_prev_q   <= hs_i;
            vs_prev_q   <= vs_i;
            sync_q      <= SYNC_W'({sync_q, dv_i, hs_i, vs_i});
        end
    end

    assign wr_en_o     = wr_en_q;
    assign wr_bank_o   = bank_q;
    assign wr_addr_o   = wr_addr_q;
    assign old_bank_o  = old_bank_q;
    assign win_valid_o = win_valid_q;
    assign row_o       = row_q;
    assign ovf_o       = ovf_q;
    assign {dv_o, hs_o, vs_o} = sync_q[SYNC_W-1 -: 3];

`ifdef FIR_COEF_LOAD_EN
    localparam int unsigned NCOEF = KSIZE * KSIZE;

    logic [4:0] coef_addr_q, coef_addr_d;
    logic       coef_busy_q, coef_busy_d;

    // Each vs rise (re)starts a full sweep of the coefficient RAM.
    always_comb begin
        coef_busy_d = coef_busy_q;
        coef_addr_d = coef_addr_q;
        if (vs_rise) begin
            coef_busy_d = 1'b1;
            coef_addr_d = 5'd0;
        end else if (coef_busy_q) begin
            if (coef_addr_q == 5'(NCOEF - 1)) begin
                coef_busy_d = 1'b0;
                coef_addr_d = 5'd0;
            end else begin
                coef_addr_d = coef_addr_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coef_busy_q <= 1'b0;
            coef_addr_q <= 5'd0;
        end else begin
            coef_busy_q <= coef_busy_d;
            coef_addr_q <= coef_addr_d;
        end
    end

    assign coef_addr_o = coef_addr_q;
    assign coef_we_o   = coef_busy_q;
    assign coef_busy_o = coef_busy_q;
`else
    assign coef_addr_o = 5'd0;
    assign coef_we_o   = 1'b0;
    assign coef_busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_fir_line_ctrl.sv
// Directed self-checking bench for fir_line_ctrl (default parameters, PIPE_LAT=4).
module tb_fir_line_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        dv_i, hs_i, vs_i;
    logic        wr_en_o;
    logic [1:0]  wr_bank_o;
    logic [10:0] wr_addr_o;
    logic [1:0]  old_bank_o;
    logic        win_valid_o;
    logic [9:0]  row_o;
    logic        ovf_o;
    logic [4:0]  coef_addr_o;
    logic        coef_we_o;
    logic        coef_busy_o;
    logic        dv_o, hs_o, vs_o;

    int n_checks = 0;
    int n_fail   = 0;

    fir_line_ctrl dut (
        .clk(clk), .rst_n(rst_n), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .wr_en_o(wr_en_o), .wr_bank_o(wr_bank_o), .wr_addr_o(wr_addr_o),
        .old_bank_o(old_bank_o), .win_valid_o(win_valid_o), .row_o(row_o), .ovf_o(ovf_o),
        .coef_addr_o(coef_addr_o), .coef_we_o(coef_we_o), .coef_busy_o(coef_busy_o),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    // Apply inputs for one clock; return 1 time unit after the rising edge.
    task automatic drive(input logic dv, input logic hs, input logic vs);
        dv_i = dv; hs_i = hs; vs_i = vs;
        @(posedge clk); #1;
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic plain_line(input int npix);
        for (int p = 0; p < npix; p++) drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({wr_en_o, wr_bank_o, wr_addr_o, old_bank_o, win_valid_o, row_o, ovf_o,
             coef_addr_o, coef_we_o, coef_busy_o, dv_o, hs_o, vs_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: en=%0b bank=%0d addr=%0d old=%0d win=%0b row=%0d ovf=%0b coef=%0d/%0b/%0b sync=%0b%0b%0b, expected all 0",
                     wr_en_o, wr_bank_o, wr_addr_o, old_bank_o, win_valid_o, row_o, ovf_o,
                     coef_addr_o, coef_we_o, coef_busy_o, dv_o, hs_o, vs_o);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (wr_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_wait_vs: wr_en=%0b expected 0", wr_en_o);
        end
    endtask

    task automatic test_line_write();
        int wins;
        logic [1:0] exp_bank, exp_old;
        vs_pulse();
        for (int l = 0; l < 6; l++) begin
            wins = 0;
            exp_bank = 2'(l % 4);
            exp_old  = (l >= 4) ? 2'((l + 1) % 4) : 2'd0;
            for (int p = 0; p < 8; p++) begin
                drive(1'b1, 1'b0, 1'b0);
                if (win_valid_o === 1'b1) wins++;
                n_checks++;
                if (wr_en_o !== 1'b1 || wr_addr_o !== 11'(p) || wr_bank_o !== exp_bank ||
                    row_o !== 10'(l) || old_bank_o !== exp_old ||
                    win_valid_o !== ((l >= 4) && (p >= 4))) begin
                    n_fail++;
                    $display("FAIL line_write l=%0d p=%0d: en=%0b addr=%0d bank=%0d row=%0d old=%0d win=%0b, expected 1/%0d/%0d/%0d/%0d/%0b",
                             l, p, wr_en_o, wr_addr_o, wr_bank_o, row_o, old_bank_o, win_valid_o,
                             p, exp_bank, l, exp_old, (l >= 4) && (p >= 4));
                end
            end
            n_checks++;
            if (wins != ((l >= 4) ? 4 : 0)) begin
                n_fail++;
                $display("FAIL window_count l=%0d: got %0d expected %0d", l, wins, (l >= 4) ? 4 : 0);
            end
            drive(1'b1, 1'b1, 1'b0);
            n_checks++;
            if (wr_en_o !== 1'b0) begin
                n_fail++;
                $display("FAIL dv_during_hs l=%0d: wr_en=%0b expected 0", l, wr_en_o);
            end
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (row_o !== 10'd6 || wr_bank_o !== 2'd2 || old_bank_o !== 2'd3) begin
            n_fail++;
            $display("FAIL empty_line: row=%0d bank=%0d old=%0d expected 6/2/3", row_o, wr_bank_o, old_bank_o);
        end
    endtask

    task automatic test_overflow();
        vs_pulse();
        for (int p = 0; p < 1600; p++) drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (wr_en_o !== 1'b1 || wr_addr_o !== 11'd1599 || ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL col_last: en=%0b addr=%0d ovf=%0b expected 1/1599/0", wr_en_o, wr_addr_o, ovf_o);
        end
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (wr_en_o !== 1'b0 || ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL col_overflow: en=%0b ovf=%0b expected 0/1", wr_en_o, ovf_o);
        end
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (wr_en_o !== 1'b1 || wr_addr_o !== 11'd0 || ovf_o !== 1'b1 || wr_bank_o !== 2'd1) begin
            n_fail++;
            $display("FAIL ovf_sticky: en=%0b addr=%0d ovf=%0b bank=%0d expected 1/0/1/1",
                     wr_en_o, wr_addr_o, ovf_o, wr_bank_o);
        end
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ovf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%0b expected 0", ovf_o);
        end
    endtask

    task automatic test_simul_edges();
        vs_pulse();
        for (int l = 0; l < 3; l++) plain_line(8);
        for (int p = 0; p < 3; p++) drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (row_o !== 10'd3 || wr_bank_o !== 2'd3) begin
            n_fail++;
            $display("FAIL simul_setup: row=%0d bank=%0d expected 3/3", row_o, wr_bank_o);
        end
        drive(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (row_o !== 10'd0 || wr_bank_o !== 2'd0 || old_bank_o !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_edges: row=%0d bank=%0d old=%0d expected 0/0/0", row_o, wr_bank_o, old_bank_o);
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 8; p++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (wr_en_o !== 1'b1 || wr_addr_o !== 11'(p) || wr_bank_o !== 2'd0 || win_valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_refill p=%0d: en=%0b addr=%0d bank=%0d win=%0b expected 1/%0d/0/0",
                         p, wr_en_o, wr_addr_o, wr_bank_o, win_valid_o, p);
            end
        end
    endtask

    task automatic test_reset_mid();
        vs_pulse();
        for (int l = 0; l < 5; l++) plain_line(8);
        for (int p = 0; p < 3; p++) drive(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en_o, wr_bank_o, wr_addr_o, old_bank_o, win_valid_o, row_o, ovf_o,
             coef_addr_o, coef_we_o, coef_busy_o, dv_o, hs_o, vs_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: en=%0b bank=%0d addr=%0d old=%0d win=%0b row=%0d, expected all 0",
                     wr_en_o, wr_bank_o, wr_addr_o, old_bank_o, win_valid_o, row_o);
        end
        drive(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (wr_en_o !== 1'b0 || row_o !== 10'd0) begin
                n_fail++;
                $display("FAIL reset_mid_ignore k=%0d: en=%0b row=%0d expected 0/0", k, wr_en_o, row_o);
            end
        end
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (wr_en_o !== 1'b1 || wr_addr_o !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_mid_resume: en=%0b addr=%0d expected 1/0", wr_en_o, wr_addr_o);
        end
    endtask

    task automatic test_sync_delay();
        logic [2:0] v, e;
        for (int n = 0; n < 12; n++) begin
            v = 3'(n * 5 + 3);
            drive(v[2], v[1], v[0]);
            if (n >= 3) begin
                e = 3'((n - 3) * 5 + 3);
                n_checks++;
                if ({dv_o, hs_o, vs_o} !== e) begin
                    n_fail++;
                    $display("FAIL sync_delay n=%0d: got %b expected %b", n, {dv_o, hs_o, vs_o}, e);
                end
            end
        end
    endtask

    task automatic test_coef_load();
        int we_cycles;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
`ifdef FIR_COEF_LOAD_EN
        we_cycles = 0;
        for (int k = 0; k < 25; k++) begin
            if (k > 0) drive(1'b0, 1'b0, 1'b1);
            if (coef_we_o === 1'b1) we_cycles++;
            n_checks++;
            if (coef_we_o !== 1'b1 || coef_busy_o !== 1'b1 || coef_addr_o !== 5'(k)) begin
                n_fail++;
                $display("FAIL coef_seq k=%0d: we=%0b busy=%0b addr=%0d expected 1/1/%0d",
                         k, coef_we_o, coef_busy_o, coef_addr_o, k);
            end
        end
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (coef_we_o !== 1'b0 || coef_busy_o !== 1'b0 || we_cycles != 25) begin
            n_fail++;
            $display("FAIL coef_done: we=%0b busy=%0b cycles=%0d expected 0/0/25", coef_we_o, coef_busy_o, we_cycles);
        end
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (coef_we_o !== 1'b1 || coef_addr_o !== 5'd0) begin
            n_fail++;
            $display("FAIL coef_restart: we=%0b addr=%0d expected 1/0", coef_we_o, coef_addr_o);
        end
`else
        we_cycles = 0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if ({coef_addr_o, coef_we_o, coef_busy_o} !== 7'd0) begin
                n_fail++;
                we_cycles++;
                $display("FAIL coef_tied k=%0d: addr=%0d we=%0b busy=%0b expected 0/0/0",
                         k, coef_addr_o, coef_we_o, coef_busy_o);
            end
            drive(1'b0, 1'b0, 1'b1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_line_write();
        test_overflow();
        test_simul_edges();
        test_reset_mid();
        test_sync_delay();
        test_coef_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
